// File: rtl/sumador_bcd_display_seq.sv
// -----------------------------------------------------------------------------
// sumador_bcd_display_seq
//
// Clocked adder with a binary-to-BCD converter and seven-segment drivers.
// On an accepted start, A and B are added into a WIDTH+1-bit sum. The sum is
// then converted to DIGITS BCD digits by a shift-add-3 (double-dabble) engine
// that handles one bit per cycle. The digits drive DIGITS registered
// active-low seven-segment outputs.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset (released synchronously upstream)
//   start  in   request to add A and B (ignored while busy)
//   A, B   in   WIDTH-bit operands
//   busy   out  high from the cycle after start up to and including the done cycle
//   done   out  one-cycle pulse when bcd/seg carry a new result
//   suma   out  WIDTH+1-bit registered sum of the last accepted operation
//   bcd    out  DIGITS*4-bit registered BCD result, units digit in [3:0]
//   seg    out  DIGITS*7 active-low segments, digit k in [7k+6:7k], bit0 = a
//
// Optional feature (macro LEADING_ZERO_BLANK_EN):
//   When the macro is defined, a digit k>0 is blanked when it and every higher
//   digit are zero. Digit 0 is never blanked, and bcd is not affected.
// -----------------------------------------------------------------------------
module sumador_bcd_display_seq #(
   parameter int WIDTH  = 4,
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      A,
   input  logic [WIDTH-1:0]      B,
   output logic                  busy,
   output logic                  done,
   output logic [WIDTH:0]        suma,
   output logic [DIGITS*4-1:0]   bcd,
   output logic [DIGITS*7-1:0]   seg
);

   localparam int SW = WIDTH + 1;          // sum width
   localparam int BW = DIGITS * 4;         // BCD scratch width
   localparam int CW = $clog2(SW + 1);     // bit counter width

   function automatic longint unsigned pow10(input int n);
      longint unsigned r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

   generate
      if (pow10(DIGITS) <= ((64'd1 << SW) - 64'd1)) begin : g_bad_digits
         $error("DIGITS too small to hold the largest WIDTH+1-bit sum");
      end
   endgenerate

   // Active-low segment pattern for one digit; codes 10-15 turn all segments off.
   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   // Full display word for a BCD value. The same function gives the reset
   // pattern, so reset and run-time blanking can never disagree.
   function automatic logic [DIGITS*7-1:0] seg_word(input logic [BW-1:0] b);
      logic [DIGITS*7-1:0] s;
`ifdef LEADING_ZERO_BLANK_EN
      logic lead_zero;
      lead_zero = 1'b1;
`endif
      s = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         s[7*k +: 7] = seg7(b[4*k +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
         // Scanning from the top, stay in "leading zero" mode until a nonzero digit appears.
         lead_zero = lead_zero & (b[4*k +: 4] == 4'd0);
         if (lead_zero && (k > 0)) s[7*k +: 7] = 7'b1111111;
`endif
      end
      return s;
   endfunction

   localparam logic [DIGITS*7-1:0] SEG_RST = seg_word({BW{1'b0}});

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t              state_q, state_d;
   logic [SW-1:0]       shift_q, shift_d;
   logic [BW-1:0]       scratch_q, scratch_d;
   logic [CW-1:0]       count_q, count_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [SW-1:0]       suma_q, suma_d;
   logic [BW-1:0]       bcd_q, bcd_d;
   logic [DIGITS*7-1:0] seg_q, seg_d;

   logic [BW-1:0]       adj;
   logic [BW+SW-1:0]    pair_sh;

   // Add-3 correction: any nibble of 5 or more would pass 9 once it is doubled.
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_adj
         assign adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5) ?
                                 scratch_q[4*gi +: 4] + 4'd3 : scratch_q[4*gi +: 4];
      end
   endgenerate

   assign pair_sh = {adj, shift_q} << 1;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      count_d   = count_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      suma_d    = suma_q;
      bcd_d     = bcd_q;
      seg_d     = seg_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               suma_d    = {1'b0, A} + {1'b0, B};
               shift_d   = {1'b0, A} + {1'b0, B};
               scratch_d = '0;
               count_d   = CW'(SW);
               busy_d    = 1'b1;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            scratch_d = pair_sh[BW+SW-1 -: BW];
            shift_d   = pair_sh[SW-1:0];
            count_d   = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               // The outputs are registered, so the copy into bcd/seg is done on
               // the edge that enters DONE. This way they are valid for the whole
               // done cycle.
               bcd_d   = pair_sh[BW+SW-1 -: BW];
               seg_d   = seg_word(pair_sh[BW+SW-1 -: BW]);
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         scratch_q <= '0;
         count_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         suma_q    <= '0;
         bcd_q     <= '0;
         seg_q     <= SEG_RST;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         count_q   <= count_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         suma_q    <= suma_d;
         bcd_q     <= bcd_d;
         seg_q     <= seg_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign suma = suma_q;
   assign bcd  = bcd_q;
   assign seg  = seg_q;

endmodule

// File: tb/tb_sumador_bcd_display_seq.sv
// -----------------------------------------------------------------------------
// Testbench for sumador_bcd_display_seq (WIDTH=4, DIGITS=2).
// The reference model works on plain integers. The expected digits come from
// division and modulo by 10, and the segment patterns come from a lookup table.
// Every cycle of every operation is checked against that model.
// -----------------------------------------------------------------------------
module tb_sumador_bcd_display_seq;

   localparam int W = 4;
   localparam int D = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic [W-1:0]   a_in, b_in;
   logic           busy, done;
   logic [W:0]     suma;
   logic [D*4-1:0] bcd;
   logic [D*7-1:0] seg;

   int n_cmp = 0;
   int n_bad = 0;
   logic [6:0] seg_tab [10];
   int shown_val;   // value currently expected on bcd/seg
   int sum_val;     // value currently expected on suma

   always #5 clk = ~clk;

   sumador_bcd_display_seq #(.WIDTH(W), .DIGITS(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (a_in),
      .B     (b_in),
      .busy  (busy),
      .done  (done),
      .suma  (suma),
      .bcd   (bcd),
      .seg   (seg)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [D*4-1:0] model_bcd(input int v);
      logic [D*4-1:0] r;
      int x;
      x = v;
      r = '0;
      for (int k = 0; k < D; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [D*7-1:0] model_seg(input int v);
      logic [D*7-1:0] r;
      int x;
      x = v;
      r = '0;
      for (int k = 0; k < D; k++) begin
         r[7*k +: 7] = seg_tab[x % 10];
`ifdef LEADING_ZERO_BLANK_EN
         if (k > 0 && x == 0) r[7*k +: 7] = 7'b1111111;
`endif
         x = x / 10;
      end
      return r;
   endfunction

   task automatic check_outputs(input logic exp_busy, input logic exp_done);
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      check("suma", 32'(suma), 32'(sum_val));
      check("bcd",  32'(bcd),  32'(model_bcd(shown_val)));
      check("seg",  32'(seg),  32'(model_seg(shown_val)));
   endtask

   // Call at a negedge with the DUT idle. poke_cyc in 1..6 pulses a start
   // with random operands while busy; that pulse must be ignored.
   task automatic run_op(input int a, input int b, input int poke_cyc);
      int s;
      s = a + b;
      a_in  = W'(a);
      b_in  = W'(b);
      start = 1'b1;
      for (int cyc = 1; cyc <= 7; cyc++) begin
         @(negedge clk);
         start = (cyc == poke_cyc);
         a_in  = W'($urandom);
         b_in  = W'($urandom);
         sum_val = s;
         if (cyc == 6) shown_val = s;
         check_outputs(cyc <= 6, cyc == 6);
      end
      $display("op A=%0d B=%0d poke=%0d -> suma=%0d bcd=%0h seg=%0h", a, b, poke_cyc, suma, bcd, seg);
   endtask

   initial begin
      seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
      seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
      seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
      seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
      seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
      shown_val = 0;
      sum_val   = 0;
      rst_n = 1'b0;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;

      repeat (2) @(negedge clk);
      check_outputs(1'b0, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check_outputs(1'b0, 1'b0);
      $display("reset: busy=%0d done=%0d bcd=%0h seg=%0h", busy, done, bcd, seg);

      run_op(9, 8, 0);      // 17
      run_op(15, 15, 3);    // 30, start in cycle 3 ignored
      run_op(0, 0, 0);      // 00
      run_op(5, 0, 0);      // back-to-back, 05

      // Reset asserted in cycle 3 of a 9+9 run
      a_in  = 4'd9;
      b_in  = 4'd9;
      start = 1'b1;
      for (int cyc = 1; cyc <= 2; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         sum_val = 18;
         check_outputs(1'b1, 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      sum_val   = 0;
      shown_val = 0;
      check_outputs(1'b0, 1'b0);
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clk);
         if (cyc == 2) rst_n = 1'b1;
         check_outputs(1'b0, 1'b0);
      end
      $display("mid-run reset: busy=%0d done=%0d bcd=%0h seg=%0h", busy, done, bcd, seg);
      run_op(9, 9, 0);      // 18

      // Randomized operations with random idle gaps and ignored start pokes
      for (int n = 0; n < 30; n++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check_outputs(1'b0, 1'b0);
         end
         run_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 6));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
